// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending stores draining to a shared memory port, with load-hazard detection
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 st_func3,
  output logic                       st_err,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hazard,
  input  logic                       fence_req,
  output logic                       fence_done,
  output logic                       mem_write,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [2:0]                 mem_func3,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [2:0]    func3_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq, hit, unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];
  assign st_err = st_valid && (st_func3 == 3'b001 ? st_addr[0] :
                               st_func3 == 3'b010 ? |st_addr[1:0] :
                               st_func3 != 3'b000);
  assign st_ready   = (count_q < FULL) && !fence_req && !rst;
  assign enq        = st_valid && st_ready && !st_err;
  assign ld_hazard  = ld_valid && hit;
  assign mem_write  = (count_q != '0) && (!ld_valid || ld_hazard) && !rst;
  assign deq        = mem_write;
  assign mem_addr   = addr_q[head_q];
  assign mem_wdata  = data_q[head_q];
  assign mem_func3  = func3_q[head_q];
  assign fence_done = count_q == '0;
  assign count      = count_q;
  // Only entries between head and head+count are live; compare word addresses.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (CW'(off) < count_q && addr_q[i][31:2] == ld_addr[31:2]) hit = 1'b1;
    end
  end
  always_comb begin
    head_d  = deq ? head_q + 1'b1 : head_q;
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(enq) - CW'(deq);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]  <= st_addr;
      data_q[tail_q]  <= st_data;
      func3_q[tail_q] <= st_func3;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer
module tb_store_buffer;
  logic        clk = 0, rst = 1;
  logic        st_valid = 0, st_ready, st_err;
  logic [31:0] st_addr = 0, st_data = 0;
  logic [2:0]  st_func3 = 0;
  logic        ld_valid = 0, ld_hazard;
  logic [31:0] ld_addr = 0;
  logic        fence_req = 0, fence_done;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_func3;
  logic [2:0]  count;
  int tests = 0, fails = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_func3(st_func3), .st_err(st_err), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .fence_req(fence_req), .fence_done(fence_done),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid = 1; st_addr = a; st_data = d; st_func3 = f;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    #1;
    tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", st_ready); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_mw got %b want 0", mem_write); end
    rst = 0;
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
    tests++; if (fence_done !== 1'b1) begin fails++; $display("FAIL rst_fdone got %b want 1", fence_done); end
    tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after got %b want 1", st_ready); end
  endtask

  task automatic test_basic();
    put(32'h10, 32'hDEADBEEF, 3'b010);
    #1;
    tests++; if (st_err !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", st_err); end
    step();
    st_valid = 0;
    #1;
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL basic_mw got %b want 1", mem_write); end
    tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL basic_addr got %h want 10", mem_addr); end
    tests++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_data got %h want deadbeef", mem_wdata); end
    tests++; if (mem_func3 !== 3'b010) begin fails++; $display("FAIL basic_f3 got %b want 010", mem_func3); end
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL basic_count got %0d want 0", count); end
    tests++; if (fence_done !== 1'b1) begin fails++; $display("FAIL basic_fdone got %b want 1", fence_done); end
  endtask

  task automatic test_fill_wrap();
    ld_valid = 1; ld_addr = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      put(32'h100 + 32'(4 * i), 32'(i + 1), 3'b010);
      #1;
      tests++; if (st_ready !== (i < 4)) begin fails++; $display("FAIL fill_ready%0d got %b want %b", i, st_ready, i < 4); end
      step();
    end
    st_valid = 0;
    #1;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d want 4", count); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL fill_ldprio got %b want 0", mem_write); end
    ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (mem_write !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * i) || mem_wdata !== 32'(i + 1))
        begin fails++; $display("FAIL drain%0d got mw=%b a=%h d=%h want mw=1 a=%h d=%h", i, mem_write, mem_addr, mem_wdata, 32'h100 + 32'(4 * i), i + 1); end
      step();
    end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL drain_count got %0d want 0", count); end
    put(32'h200, 32'h66, 3'b010);
    step();
    st_valid = 0;
    #1;
    tests++; if (mem_write !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h66)
      begin fails++; $display("FAIL wrap got mw=%b a=%h d=%h want mw=1 a=200 d=66", mem_write, mem_addr, mem_wdata); end
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_count got %0d want 0", count); end
  endtask

  task automatic test_hazard();
    ld_valid = 1; ld_addr = 32'h500;
    put(32'h500, 32'h1, 3'b010);
    #1;
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_same_cycle got %b want 0", ld_hazard); end
    step();
    st_valid = 0; ld_valid = 0;
    step();
    put(32'h21, 32'hAB, 3'b000);
    step();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h20;
    #1;
    tests++; if (ld_hazard !== 1'b1) begin fails++; $display("FAIL haz_hit got %b want 1", ld_hazard); end
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL haz_mw got %b want 1", mem_write); end
    step();
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_clear got %b want 0", ld_hazard); end
    ld_valid = 0;
    put(32'h21, 32'hAB, 3'b000);
    step();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h24;
    #1;
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_miss got %b want 0", ld_hazard); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL haz_miss_mw got %b want 0", mem_write); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL haz_miss_count got %0d want 1", count); end
    ld_valid = 0;
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL haz_drain got %0d want 0", count); end
  endtask

  task automatic test_misaligned();
    put(32'h12, 32'h5, 3'b010);
    #1;
    tests++; if (st_err !== 1'b1) begin fails++; $display("FAIL mis_sw got %b want 1", st_err); end
    step();
    tests++; if (count !== 3'd0 || mem_write !== 1'b0) begin fails++; $display("FAIL mis_sw_drop got count=%0d mw=%b want 0 0", count, mem_write); end
    put(32'h13, 32'h5, 3'b001);
    #1;
    tests++; if (st_err !== 1'b1) begin fails++; $display("FAIL mis_sh got %b want 1", st_err); end
    step();
    tests++; if (count !== 3'd0 || mem_write !== 1'b0) begin fails++; $display("FAIL mis_sh_drop got count=%0d mw=%b want 0 0", count, mem_write); end
    put(32'h10, 32'h5, 3'b011);
    #1;
    tests++; if (st_err !== 1'b1) begin fails++; $display("FAIL bad_f3 got %b want 1", st_err); end
    put(32'h12, 32'h5, 3'b001);
    #1;
    tests++; if (st_err !== 1'b0) begin fails++; $display("FAIL sh_ok got %b want 0", st_err); end
    st_valid = 0; st_func3 = 3'b111;
    #1;
    tests++; if (st_err !== 1'b0) begin fails++; $display("FAIL err_novalid got %b want 0", st_err); end
  endtask

  task automatic test_back_to_back();
    ld_valid = 1; ld_addr = 32'h2000;
    put(32'h300, 32'hA1, 3'b010);
    step();
    put(32'h304, 32'hB2, 3'b010);
    step();
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_pre got %0d want 2", count); end
    ld_valid = 0;
    put(32'h308, 32'hC3, 3'b010);
    #1;
    tests++; if (mem_write !== 1'b1 || mem_addr !== 32'h300 || st_ready !== 1'b1)
      begin fails++; $display("FAIL b2b_oldest got mw=%b a=%h rdy=%b want 1 300 1", mem_write, mem_addr, st_ready); end
    step();
    st_valid = 0;
    #1;
    tests++; if (count !== 3'd2 || mem_addr !== 32'h304) begin fails++; $display("FAIL b2b_same got count=%0d a=%h want 2 304", count, mem_addr); end
    step();
    tests++; if (mem_addr !== 32'h308 || mem_wdata !== 32'hC3) begin fails++; $display("FAIL b2b_last got a=%h d=%h want 308 c3", mem_addr, mem_wdata); end
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_end got %0d want 0", count); end
  endtask

  task automatic test_fence();
    ld_valid = 1; ld_addr = 32'h2000;
    put(32'h600, 32'h1, 3'b010);
    step();
    put(32'h604, 32'h2, 3'b010);
    step();
    ld_valid = 0; fence_req = 1;
    put(32'h608, 32'h3, 3'b010);
    #1;
    tests++; if (st_ready !== 1'b0 || fence_done !== 1'b0) begin fails++; $display("FAIL fence_block got rdy=%b fd=%b want 0 0", st_ready, fence_done); end
    step();
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL fence_drain got %0d want 1", count); end
    step();
    tests++; if (count !== 3'd0 || fence_done !== 1'b1) begin fails++; $display("FAIL fence_done got count=%0d fd=%b want 0 1", count, fence_done); end
    st_valid = 0; fence_req = 0;
  endtask

  task automatic test_reset_mid();
    ld_valid = 1; ld_addr = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      put(32'h400 + 32'(4 * i), 32'(i), 3'b010);
      step();
    end
    st_valid = 0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL rmid_pre got %0d want 3", count); end
    ld_valid = 0; rst = 1;
    #1;
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rmid_mw got %b want 0", mem_write); end
    step();
    rst = 0;
    #1;
    tests++; if (count !== 3'd0 || fence_done !== 1'b1 || mem_write !== 1'b0)
      begin fails++; $display("FAIL rmid_after got count=%0d fd=%b mw=%b want 0 1 0", count, fence_done, mem_write); end
    step();
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rmid_late got %b want 0", mem_write); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_wrap();
    test_hazard();
    test_misaligned();
    test_back_to_back();
    test_fence();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
